// File: rtl/target_sync_ctrl.sv
// Copies the main-network weight memory into the target-network weight RAM,
// one word per READ/WAIT/WRITE pass, addresses 0..DEPTH-1, once per sync_start.
module target_sync_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_start,
  output logic                  sync_busy,
  output logic                  sync_done,
  output logic                  src_en,
  output logic [ADDR_BITS-1:0]  src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  dst_en,
  output logic                  dst_we,
  output logic [ADDR_BITS-1:0]  dst_addr,
  output logic [DATA_WIDTH-1:0] dst_data,
  input  logic                  dst_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Terminal index; DEPTH == 2**ADDR_BITS lands on the all-ones address.
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_src_en;
  logic [ADDR_BITS-1:0]  r_src_addr;
  logic                  r_dst_en;
  logic [ADDR_BITS-1:0]  r_dst_addr;
  logic [DATA_WIDTH-1:0] r_dst_data;

  logic [ADDR_BITS-1:0]  w_idx_next;
  logic                  w_last;

  assign w_idx_next = r_idx + ADDR_BITS'(1);
  assign w_last     = (r_idx == LAST_IDX);

  // Outputs are registered alongside the state so each reflects the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_src_en   <= 1'b0;
      r_src_addr <= '0;
      r_dst_en   <= 1'b0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sync_start) begin
            r_idx      <= '0;
            r_state    <= S_READ;
            r_busy     <= 1'b1;
            r_src_en   <= 1'b1;
            r_src_addr <= '0;
          end
        end
        S_READ: begin
          r_src_en <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_dst_data <= src_data;
          r_dst_en   <= 1'b1;
          r_dst_addr <= r_idx;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          // Everything on the destination side holds until the RAM accepts.
          if (dst_ready) begin
            r_dst_en <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx      <= w_idx_next;
              r_src_en   <= 1'b1;
              r_src_addr <= w_idx_next;
              r_state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_src_en <= 1'b0;
          r_dst_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign sync_busy = r_busy;
  assign sync_done = r_done;
  assign src_en    = r_src_en;
  assign src_addr  = r_src_addr;
  assign dst_en    = r_dst_en;
  assign dst_we    = r_dst_en;
  assign dst_addr  = r_dst_addr;
  assign dst_data  = r_dst_data;

endmodule

// File: tb/tb_target_sync_ctrl.sv
// Bench for target_sync_ctrl: cycle tables for DEPTH=4, plus reset, DEPTH=1 and DEPTH=32 runs.
module tb_target_sync_ctrl;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic st4, busy4, done4, se4, de4, dwe4, rdy4;
  logic [4:0] sa4, da4;
  logic [31:0] sd4, dd4;
  // DEPTH=1 instance
  logic st1, busy1, done1, se1, de1, dwe1;
  logic [4:0] sa1, da1;
  logic [31:0] sd1, dd1;
  // DEPTH=32 instance
  logic st32, busy32, done32, se32, de32, dwe32;
  logic [4:0] sa32, da32;
  logic [31:0] sd32, dd32;

  logic        rdy_hi;
  logic        clr;
  logic [31:0] smem [32];
  logic [31:0] dmem4 [32];
  logic [31:0] dmem1 [32];
  logic [31:0] dmem32 [32];
  int wr4, wr1, wr32, zero32;
  int last32;

  int total = 0;
  int bad   = 0;

  target_sync_ctrl #(.DATA_WIDTH(32), .ADDR_BITS(5), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .sync_start(st4), .sync_busy(busy4), .sync_done(done4),
    .src_en(se4), .src_addr(sa4), .src_data(sd4), .dst_en(de4), .dst_we(dwe4),
    .dst_addr(da4), .dst_data(dd4), .dst_ready(rdy4));

  target_sync_ctrl #(.DATA_WIDTH(32), .ADDR_BITS(5), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .sync_start(st1), .sync_busy(busy1), .sync_done(done1),
    .src_en(se1), .src_addr(sa1), .src_data(sd1), .dst_en(de1), .dst_we(dwe1),
    .dst_addr(da1), .dst_data(dd1), .dst_ready(rdy_hi));

  target_sync_ctrl #(.DATA_WIDTH(32), .ADDR_BITS(5), .DEPTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .sync_start(st32), .sync_busy(busy32), .sync_done(done32),
    .src_en(se32), .src_addr(sa32), .src_data(sd32), .dst_en(de32), .dst_we(dwe32),
    .dst_addr(da32), .dst_data(dd32), .dst_ready(rdy_hi));

  // Source memories: one-cycle read latency
  always_ff @(posedge clk) begin
    if (se4)  sd4  <= smem[sa4];
    if (se1)  sd1  <= smem[sa1];
    if (se32) sd32 <= smem[sa32];
  end

  // Destination RAM models with write logging
  always_ff @(posedge clk) begin
    if (clr) begin
      wr4 <= 0; wr1 <= 0; wr32 <= 0; zero32 <= 0; last32 <= -1;
      for (int k = 0; k < 32; k++) begin
        dmem4[k] <= SENT; dmem1[k] <= SENT; dmem32[k] <= SENT;
      end
    end else begin
      if (de4 && dwe4 && rdy4) begin dmem4[da4] <= dd4; wr4 <= wr4 + 1; end
      if (de1 && dwe1) begin dmem1[da1] <= dd1; wr1 <= wr1 + 1; end
      if (de32 && dwe32) begin
        dmem32[da32] <= dd32;
        wr32   <= wr32 + 1;
        last32 <= int'(da32);
        if (da32 == 5'd0) zero32 <= zero32 + 1;
      end
    end
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic        bz;
    logic        dn;
    logic        se;
    logic [4:0]  sa;
    logic        de;
    logic [4:0]  da;
    logic [31:0] dd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] av(input int i);
    return 32'hC0DE_1000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic vec_t mk(input int st, input int rd, input int bz, input int dn,
                              input int se, input int sa, input int de, input int da,
                              input logic [31:0] dd);
    vec_t v;
    v.st = 1'(st); v.rd = 1'(rd); v.bz = 1'(bz); v.dn = 1'(dn);
    v.se = 1'(se); v.sa = 5'(sa); v.de = 1'(de); v.da = 5'(da); v.dd = dd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_mems();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Nominal DEPTH=4 run; optional start pulses while busy (WAIT) and in DONE.
  task automatic load_t1(input int pulse);
    vecs.delete();
    vecs.push_back(mk(0,     1, 1, 0, 1, 0, 0, 0, 32'h0));  // 1  READ 0
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 0, 0, 32'h0));  // 2  WAIT
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 1, 0, av(0)));  // 3  WRITE 0
    vecs.push_back(mk(0,     1, 1, 0, 1, 1, 0, 0, 32'h0));  // 4
    vecs.push_back(mk(pulse, 1, 1, 0, 0, 0, 0, 0, 32'h0));  // 5
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 1, 1, av(1)));  // 6
    vecs.push_back(mk(0,     1, 1, 0, 1, 2, 0, 0, 32'h0));  // 7
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 0, 0, 32'h0));  // 8
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 1, 2, av(2)));  // 9
    vecs.push_back(mk(0,     1, 1, 0, 1, 3, 0, 0, 32'h0));  // 10
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 0, 0, 32'h0));  // 11
    vecs.push_back(mk(0,     1, 1, 0, 0, 0, 1, 3, av(3)));  // 12
    vecs.push_back(mk(pulse, 1, 1, 1, 0, 0, 0, 0, 32'h0));  // 13 DONE
    vecs.push_back(mk(0,     1, 0, 0, 0, 0, 0, 0, 32'h0));  // 14 IDLE
  endtask

  // Backpressure: dst_ready low in cycles 6..8
  task automatic load_t2();
    vecs.delete();
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 32'h0));  // 1
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0));  // 2
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, av(0)));  // 3
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 32'h0));  // 4
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0));  // 5
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, av(1)));  // 6
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, av(1)));  // 7
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, av(1)));  // 8
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, av(1)));  // 9 accepted
    vecs.push_back(mk(0, 1, 1, 0, 1, 2, 0, 0, 32'h0));  // 10
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0));  // 11
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 2, av(2)));  // 12
    vecs.push_back(mk(0, 1, 1, 0, 1, 3, 0, 0, 32'h0));  // 13
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0));  // 14
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 3, av(3)));  // 15
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 32'h0));  // 16 DONE
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0));  // 17
  endtask

  // Start sampled at edge 0; row i describes cycle i+1.
  task automatic run_table(input string tag);
    st4 = 1'b1; rdy4 = 1'b1;
    tick();
    foreach (vecs[i]) begin
      st4  = vecs[i].st;
      rdy4 = vecs[i].rd;
      chk($sformatf("%s_c%0d_busy", tag, i + 1), 32'(busy4), 32'(vecs[i].bz));
      chk($sformatf("%s_c%0d_done", tag, i + 1), 32'(done4), 32'(vecs[i].dn));
      chk($sformatf("%s_c%0d_src_en", tag, i + 1), 32'(se4), 32'(vecs[i].se));
      chk($sformatf("%s_c%0d_dst_en", tag, i + 1), 32'(de4), 32'(vecs[i].de));
      chk($sformatf("%s_c%0d_dst_we", tag, i + 1), 32'(dwe4), 32'(vecs[i].de));
      if (vecs[i].se)
        chk($sformatf("%s_c%0d_src_addr", tag, i + 1), 32'(sa4), 32'(vecs[i].sa));
      if (vecs[i].de) begin
        chk($sformatf("%s_c%0d_dst_addr", tag, i + 1), 32'(da4), 32'(vecs[i].da));
        chk($sformatf("%s_c%0d_dst_data", tag, i + 1), dd4, vecs[i].dd);
      end
      tick();
    end
    st4 = 1'b0; rdy4 = 1'b1;
  endtask

  task automatic check_d4_mem(input string tag);
    chk({tag, "_writes"}, 32'(wr4), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_mem%0d", tag, k), dmem4[k], av(k));
    chk({tag, "_mem4_untouched"}, dmem4[4], SENT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int cnt;
    rst_n = 1'b0;
    st4 = 1'b0; st1 = 1'b0; st32 = 1'b0;
    rdy4 = 1'b1; rdy_hi = 1'b1; clr = 1'b0;
    for (int k = 0; k < 32; k++) smem[k] = av(k);
    #3;
    chk("reset_busy", 32'(busy4), 32'd0);
    chk("reset_done", 32'(done4), 32'd0);
    chk("reset_src_en", 32'(se4), 32'd0);
    chk("reset_dst_en", 32'(de4), 32'd0);
    chk("reset_dst_data", dd4, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_mems();

    // T1 nominal copy
    load_t1(0);
    run_table("t1");
    check_d4_mem("t1");

    // T2 backpressure
    clear_mems();
    load_t2();
    run_table("t2");
    check_d4_mem("t2");

    // T3 starts while busy and in DONE are dropped
    clear_mems();
    load_t1(1);
    run_table("t3");
    tick();
    tick();
    chk("t3_busy_after", 32'(busy4), 32'd0);
    check_d4_mem("t3");

    // T4 reset in cycle 7
    clear_mems();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy4), 32'd0);
    chk("t4_done", 32'(done4), 32'd0);
    chk("t4_src_en", 32'(se4), 32'd0);
    chk("t4_src_addr", 32'(sa4), 32'd0);
    chk("t4_dst_en", 32'(de4), 32'd0);
    chk("t4_dst_we", 32'(dwe4), 32'd0);
    chk("t4_dst_addr", 32'(da4), 32'd0);
    chk("t4_dst_data", dd4, 32'd0);
    chk("t4_writes", 32'(wr4), 32'd2);
    chk("t4_mem0", dmem4[0], av(0));
    chk("t4_mem1", dmem4[1], av(1));
    chk("t4_mem2", dmem4[2], SENT);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done4) seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done4 || busy4) seen++;
    end
    chk("t4_no_done_no_busy", 32'(seen), 32'd0);
    clear_mems();
    load_t1(0);
    run_table("t4r");
    check_d4_mem("t4r");

    // T5 DEPTH=1
    clear_mems();
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    chk("t5_c1_src_en", 32'(se1), 32'd1);
    tick();
    tick();
    chk("t5_c3_dst_en", 32'(de1), 32'd1);
    chk("t5_c3_dst_addr", 32'(da1), 32'd0);
    chk("t5_c3_dst_data", dd1, av(0));
    chk("t5_c3_done", 32'(done1), 32'd0);
    tick();
    chk("t5_c4_done", 32'(done1), 32'd1);
    chk("t5_c4_busy", 32'(busy1), 32'd1);
    tick();
    chk("t5_c5_done", 32'(done1), 32'd0);
    chk("t5_c5_busy", 32'(busy1), 32'd0);
    chk("t5_writes", 32'(wr1), 32'd1);
    chk("t5_mem0", dmem1[0], av(0));

    // T6 DEPTH=32, full address range
    for (int k = 0; k < 32; k++) smem[k] = $urandom();
    clear_mems();
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    cnt = 1;
    while (!done32 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("t6_done_cycle", 32'(cnt), 32'd97);
    tick();
    chk("t6_busy_after", 32'(busy32), 32'd0);
    chk("t6_done_pulse", 32'(done32), 32'd0);
    chk("t6_writes", 32'(wr32), 32'd32);
    chk("t6_last_addr", 32'(last32), 32'd31);
    chk("t6_addr0_writes", 32'(zero32), 32'd1);
    seen = 0;
    for (int k = 0; k < 32; k++)
      if (dmem32[k] !== smem[k]) seen++;
    chk("t6_word_mismatches", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
